// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the FFT frame sequencer
package fft_pkg;

  localparam int NUMSTAGES_DEF  = 5;
  localparam int NUMSAMPLES_DEF = 2 ** NUMSTAGES_DEF;
  localparam int PIPE_LAT_DEF   = 2;

  localparam int CNT_W   = NUMSTAGES_DEF - 2;
  localparam int ADDR_W  = NUMSTAGES_DEF;
  localparam int STAGE_W = 3;
  localparam int CNT_MAX = 2 ** CNT_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD,
    S_FINISH
  } state_e;

endpackage

// File: rtl/fft_sequencer_stage_counter.sv
// rtl/fft_sequencer_stage_counter.sv - butterfly counter, stage index and twiddle address
module stage_counter
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = NUMSTAGES_DEF,
  parameter int CW        = NUMSTAGES - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               advance_stage,
  output logic [CW-1:0]      counter_r,
  output logic [STAGE_W-1:0] stage_num_r,
  output logic [CW-1:0]      tw_addr,
  output logic               wrap,
  output logic               last_stage
);

  logic [CW-1:0]      counter_q, counter_d;
  logic [CW-1:0]      tw_q, tw_d;
  logic [STAGE_W-1:0] stage_q, stage_d;

  assign wrap       = (counter_q == CW'(2 ** CW - 1));
  assign last_stage = (stage_q == STAGE_W'(NUMSTAGES - 1));

  // Next counter/stage; the twiddle address is derived from the next values so it stays aligned
  always_comb begin
    counter_d = counter_q;
    stage_d   = stage_q;
    if (clear) begin
      counter_d = '0;
      stage_d   = '0;
    end else begin
      if (enable) begin
        counter_d = counter_q + CW'(1);
      end
      if (advance_stage && !last_stage) begin
        stage_d = stage_q + STAGE_W'(1);
      end
    end
    tw_d = counter_d << stage_d;
  end

  // Counter, stage and twiddle registers
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      stage_q   <= '0;
      tw_q      <= '0;
    end else begin
      counter_q <= counter_d;
      stage_q   <= stage_d;
      tw_q      <= tw_d;
    end
  end

  assign counter_r   = counter_q;
  assign stage_num_r = stage_q;
  assign tw_addr     = tw_q;

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - frame sequencer: load, staged compute with drain, unload, done
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES  = NUMSTAGES_DEF,
  parameter int NUMSAMPLES = NUMSAMPLES_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] load_addr,
  output logic [NUMSTAGES-3:0] counter_r,
  output logic [2:0]           stage_num_r,
  output logic                 compute_en,
  output logic [NUMSTAGES-3:0] tw_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMSTAGES-1:0] out_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int AW         = NUMSTAGES;
  localparam int DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

  state_e        state_q, state_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          in_ready_q, in_ready_d;
  logic          compute_en_q, compute_en_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic cnt_en, cnt_clear, cnt_adv, cnt_wrap, cnt_last;
  logic in_beat, out_beat, stage_end;

  assign in_beat   = in_valid & in_ready_q;
  assign out_beat  = out_valid_q & out_ready;
  assign cnt_en    = (state_q == S_COMPUTE);
  assign cnt_clear = (state_q == S_IDLE);

  stage_counter #(
    .NUMSTAGES (NUMSTAGES),
    .CW        (NUMSTAGES - 2)
  ) u_stage_counter (
    .clk           (clk),
    .rst           (rst),
    .enable        (cnt_en),
    .clear         (cnt_clear),
    .advance_stage (cnt_adv),
    .counter_r     (counter_r),
    .stage_num_r   (stage_num_r),
    .tw_addr       (tw_addr),
    .wrap          (cnt_wrap),
    .last_stage    (cnt_last)
  );

  // Next state, address counters, and registered outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    out_addr_d  = out_addr_q;
    drain_d     = drain_q;
    cnt_adv     = 1'b0;
    stage_end   = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_addr_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_beat) begin
          load_addr_d = load_addr_q + AW'(1);
          if (load_addr_q == AW'(NUMSAMPLES - 1)) begin
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (cnt_wrap) begin
          if (PIPE_LAT == 0) begin
            stage_end = 1'b1;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_LAST)) begin
          stage_end = 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_beat) begin
          out_addr_d = out_addr_q + AW'(1);
          if (out_addr_q == AW'(NUMSAMPLES - 1)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stage_end) begin
      if (cnt_last) begin
        state_d    = S_UNLOAD;
        out_addr_d = '0;
      end else begin
        state_d = S_COMPUTE;
        cnt_adv = 1'b1;
      end
    end

    in_ready_d   = (state_d == S_LOAD);
    compute_en_d = (state_d == S_COMPUTE);
    out_valid_d  = (state_d == S_UNLOAD);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_FINISH));
    done_d       = (state_d == S_FINISH);
  end

  // State and output registers; reset wins over any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_addr_q  <= '0;
      out_addr_q   <= '0;
      drain_q      <= '0;
      in_ready_q   <= 1'b0;
      compute_en_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      out_addr_q   <= out_addr_d;
      drain_q      <= drain_d;
      in_ready_q   <= in_ready_d;
      compute_en_q <= compute_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign load_addr  = load_addr_q;
  assign out_addr   = out_addr_q;
  assign compute_en = compute_en_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - scoreboard bench for the FFT frame sequencer
module tb_fft_sequencer;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;

  logic       in_ready, compute_en, out_valid, busy, done;
  logic [4:0] load_addr, out_addr;
  logic [2:0] counter_r, stage_num_r, tw_addr;

  logic       in_ready0, compute_en0, out_valid0, busy0, done0;
  logic [4:0] load_addr0, out_addr0;
  logic [2:0] counter_r0, stage_num_r0, tw_addr0;

  always #5 clk = ~clk;

  fft_sequencer #(.NUMSTAGES(5), .NUMSAMPLES(32), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .load_addr(load_addr), .counter_r(counter_r), .stage_num_r(stage_num_r),
    .compute_en(compute_en), .tw_addr(tw_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .busy(busy), .done(done)
  );

  fft_sequencer #(.NUMSTAGES(5), .NUMSAMPLES(32), .PIPE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .load_addr(load_addr0), .counter_r(counter_r0), .stage_num_r(stage_num_r0),
    .compute_en(compute_en0), .tw_addr(tw_addr0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_addr(out_addr0), .busy(busy0), .done(done0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int q_load[$], q_comp[$], q_comp0[$], q_out[$], q_out0[$];
  int q_done[$], q_done0[$], q_inc[$], q_ovc[$];
  int in_cnt, ov_cnt, cen_run, cen_run0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected responses for one frame, computed from the frame shape and the stalls applied
  task automatic push_frame(input int in_stall, input int out_stall);
    for (int i = 0; i < 32; i++) begin
      q_load.push_back(i);
      q_out.push_back(i);
      q_out0.push_back(i);
    end
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 8; c++) begin
        q_comp.push_back(s * 64 + c * 8 + ((c << s) & 7));
        q_comp0.push_back(s * 64 + c * 8 + ((c << s) & 7));
      end
    end
    q_done.push_back(cyc + 115 + in_stall + out_stall);
    q_inc.push_back(32 + in_stall);
    q_ovc.push_back(32 + out_stall);
    q_done0.push_back(cyc + 105 + in_stall);
  endtask

  // Monitor: pops expectations whenever either sequencer presents a beat, an enabled cycle or done
  always @(negedge clk) begin
    if (rst) begin
      q_load.delete(); q_comp.delete(); q_comp0.delete(); q_out.delete(); q_out0.delete();
      q_done.delete(); q_done0.delete(); q_inc.delete(); q_ovc.delete();
      in_cnt = 0; ov_cnt = 0; cen_run = 0; cen_run0 = 0;
    end else begin
      if (in_ready) in_cnt++;
      if (out_valid) ov_cnt++;
      if (in_valid && in_ready) begin
        if (q_load.size() == 0) chk("load_extra", int'(load_addr), -1);
        else chk("load_addr", int'(load_addr), q_load.pop_front());
      end
      if (compute_en) begin
        cen_run++;
        if (q_comp.size() == 0) chk("comp_extra", int'({stage_num_r, counter_r, tw_addr}), -1);
        else chk("stage_cnt_tw", int'({stage_num_r, counter_r, tw_addr}), q_comp.pop_front());
      end else if (cen_run != 0) begin
        chk("compute_burst", cen_run, 8);
        cen_run = 0;
      end
      if (compute_en0) begin
        cen_run0++;
        if (q_comp0.size() == 0) chk("comp0_extra", int'({stage_num_r0, counter_r0, tw_addr0}), -1);
        else chk("p0_stage_cnt_tw", int'({stage_num_r0, counter_r0, tw_addr0}), q_comp0.pop_front());
      end else if (cen_run0 != 0) begin
        chk("p0_compute_burst", cen_run0, 40);
        cen_run0 = 0;
      end
      if (out_valid && out_ready) begin
        if (q_out.size() == 0) chk("out_extra", int'(out_addr), -1);
        else chk("out_addr", int'(out_addr), q_out.pop_front());
      end
      if (out_valid0 && out_ready) begin
        if (q_out0.size() == 0) chk("out0_extra", int'(out_addr0), -1);
        else chk("p0_out_addr", int'(out_addr0), q_out0.pop_front());
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_extra", cyc, -1);
        else begin
          chk("done_cycle", cyc, q_done.pop_front());
          chk("in_ready_cycles", in_cnt, q_inc.pop_front());
          chk("out_valid_cycles", ov_cnt, q_ovc.pop_front());
        end
        in_cnt = 0;
        ov_cnt = 0;
      end
      if (done0) begin
        if (q_done0.size() == 0) chk("done0_extra", cyc, -1);
        else chk("p0_done_cycle", cyc, q_done0.pop_front());
      end
    end
  end

  task automatic run_frame(input int in_stall, input int out_stall, input bit ign);
    int in_hold, out_hold;
    bit did_in, did_out, did_c, did_u, got;
    in_hold = 0; out_hold = 0;
    did_in = 0; did_out = 0; did_c = 0; did_u = 0; got = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    push_frame(in_stall, out_stall);
    start = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      tick();
      start = 1'b0;
      if (done) begin
        got = 1;
        chk("busy_at_done", busy, 0);
      end else begin
        if (in_hold > 0) begin
          chk("load_addr_hold", int'(load_addr), 10);
          in_hold--;
          if (in_hold == 0) in_valid = 1'b1;
        end else if (!did_in && in_stall > 0 && in_ready && load_addr == 5'd10) begin
          in_valid = 1'b0;
          in_hold = in_stall;
          did_in = 1;
        end
        if (out_hold > 0) begin
          chk("out_valid_held", out_valid, 1);
          chk("out_addr_hold", int'(out_addr), 31);
          out_hold--;
          if (out_hold == 0) out_ready = 1'b1;
        end else if (!did_out && out_stall > 0 && out_valid && out_addr == 5'd31) begin
          out_ready = 1'b0;
          out_hold = out_stall;
          did_out = 1;
        end
        if (ign && !did_c && compute_en && stage_num_r == 3'd1) begin
          start = 1'b1;
          did_c = 1;
        end
        if (ign && !did_u && out_valid && out_addr == 5'd5) begin
          start = 1'b1;
          did_u = 1;
        end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    tick();
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_compute_en", compute_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addrs", int'({load_addr, out_addr}), 0);
    chk("rst_cnt_stage_tw", int'({counter_r, stage_num_r, tw_addr}), 0);
    chk("rst_p0_busy", busy0, 0);
    rst = 1'b0;
    tick();

    run_frame(0, 0, 1'b0);
    run_frame(3, 5, 1'b0);
    run_frame(0, 0, 1'b1);

    in_valid = 1'b1;
    out_ready = 1'b1;
    push_frame(0, 0);
    start = 1'b1;
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      tick();
      start = 1'b0;
      if (compute_en && stage_num_r == 3'd2) found = 1;
    end
    if (!found) chk("stage2_timeout", 0, 1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_compute_en", compute_en, 0);
    chk("midrst_counter", int'(counter_r), 0);
    chk("midrst_stage", int'(stage_num_r), 0);
    chk("midrst_outputs", int'({in_ready, out_valid, done}), 0);
    chk("midrst_p0_busy", busy0, 0);
    rst = 1'b0;
    tick();

    run_frame(0, 0, 1'b0);
    repeat (3) tick();
    chk("scoreboard_empty", q_load.size() + q_comp.size() + q_comp0.size() + q_out.size()
        + q_out0.size() + q_done.size() + q_done0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
